// File: rtl/ripple_down_timer.sv
// ripple_down_timer: loadable down-counter/timer with a one-cycle terminal
// count pulse.
//
// States: IDLE (out holds, en ignored) and RUN (one decrement per enabled
// edge). Per-edge priority is rst > load > en.
//
// Build option: define DOWN_TIMER_AUTORELOAD_EN to make the timer periodic.
// - After the terminal edge it stays in RUN with out == 0 for one enabled
//   period.
// - The next enabled edge then reloads the value captured by the last load.
// - Without the macro the timer drops to IDLE at terminal and holds 0.
//
// Handshake: none. load and en are plain level controls sampled on every
// rising clock edge. There is no valid/ready pair on this block.
module ripple_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // Zero flag follows the registered count directly.
    assign zero = (out == CNT_ZERO);

    // Timer FSM: count register, reload register, tc pulse and busy flag.
    // busy is registered alongside state so it always mirrors RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out        <= CNT_ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            reload_reg <= CNT_ZERO;
        end else begin
            // tc is a single-cycle pulse; it is only raised on the terminal edge.
            tc <= 1'b0;
            if (load) begin
                // A load always wins, including on the terminal edge,
                // so no tc is produced here.
                reload_reg <= load_val;
                out        <= load_val;
                if (load_val != CNT_ZERO) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == RUN && en) begin
                if (out > CNT_ONE) begin
                    out <= out - CNT_ONE;
                end else if (out == CNT_ONE) begin
                    // Terminal edge.
                    out <= CNT_ZERO;
                    tc  <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                    if (reload_reg == CNT_ZERO) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                    // out == 0 in RUN: this is the reload period after a terminal.
                    if (reload_reg != CNT_ZERO) begin
                        out <= reload_reg;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    // Without auto-reload, RUN is never entered or kept with a
                    // zero count. Holding here keeps the counter from underflowing.
                    out <= out;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_down_timer.sv
// Testbench for ripple_down_timer.
// - Runs directed scenarios and then a randomized phase.
// - Every clock edge is checked against a behavioural model of the timer
//   rules kept in this bench.
module tb_ripple_down_timer;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             tc;
  logic             busy;

  always #5 clk = ~clk;

  ripple_down_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .out      (out),
    .zero     (zero),
    .tc       (tc),
    .busy     (busy)
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad   = 0;

  // Model state as plain integers:
  // - m_cnt: the value the count should show.
  // - m_active: the timer is counting.
  // - m_period: the last loaded value.
  int m_cnt;
  bit m_active;
  int m_period;
  bit m_tc;

  int exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_active = 0;
    m_period = 0;
    m_tc     = 0;
  endtask

  task automatic model_edge(input bit l, input int v, input bit e);
    m_tc = 0;
    if (l) begin
      m_period = v;
      m_cnt    = v;
      m_active = (v != 0);
    end else if (m_active && e) begin
      if (m_cnt >= 2) begin
        m_cnt = m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt = 0;
        m_tc  = 1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        m_active = (m_period != 0);
`else
        m_active = 0;
`endif
      end else begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
        if (m_period != 0) m_cnt = m_period;
        else m_active = 0;
`endif
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
  task automatic step(input bit l, input int v, input bit e);
    @(negedge clk);
    load     = l;
    load_val = WIDTH'(v);
    en       = e;
    @(posedge clk);
    model_edge(l, v, e);
    #1;
    check("out",  int'(out),  m_cnt);
    check("tc",   int'(tc),   int'(m_tc));
    check("busy", int'(busy), int'(m_active));
    check("zero", int'(zero), int'(m_cnt == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    load_val = '0;
    en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs enabled edges until tc rises and returns the edge count, or -1 on timeout.
  task automatic edges_to_tc(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step(0, 0, 1);
      if (tc === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int tc_seen;
    rst = 1'b1;
    load = 1'b0;
    load_val = '0;
    en = 1'b0;
    model_reset();
    #1;
    check("rst_out",  int'(out),  0);
    check("rst_tc",   int'(tc),   0);
    check("rst_busy", int'(busy), 0);
    check("rst_zero", int'(zero), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-count: load 9, three enabled edges, then an asynchronous reset between edges.
    step(1, 9, 0);
    repeat (3) step(0, 0, 1);
    check("mid_out6", int'(out), 6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_out",  int'(out),  0);
    check("arst_busy", int'(busy), 0);
    check("arst_tc",   int'(tc),   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 0, 1);

    // Basic countdown from 5, then hold at 0 for 10 more cycles.
    exp_q = '{5, 4, 3, 2, 1, 0};
    step(1, 5, 1);
    check("cd_first", int'(out), exp_q.pop_front());
    while (exp_q.size() > 0) begin
      step(0, 0, 1);
      check("cd_seq", int'(out), exp_q.pop_front());
    end
    check("cd_tc", int'(tc), 1);
    tc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1);
      tc_seen += int'(tc);
    end
`ifndef DOWN_TIMER_AUTORELOAD_EN
    check("cd_hold_tc", tc_seen, 0);
`endif

    // Enable gaps: load 3, then en pattern 1,0,0,1,0,1.
    step(1, 3, 0);
    tc_seen = 0;
    exp_q = '{2, 2, 2, 1, 1, 0};
    foreach (exp_q[i]) begin
      step(0, 0, (i == 0 || i == 3 || i == 5));
      check("gap_seq", int'(out), exp_q[i]);
      tc_seen += int'(tc);
    end
    check("gap_tc_count", tc_seen, 1);

    // Priority: load together with en wins; loading 0 while running goes idle.
    step(1, 7, 0);
    repeat (3) step(0, 0, 1);
    step(1, 2, 1);
    check("prio_out", int'(out), 2);
    step(1, 0, 1);
    check("load0_busy", int'(busy), 0);
    check("load0_tc",   int'(tc),   0);

    // A load on the terminal edge suppresses tc.
    step(1, 1, 0);
    step(1, 4, 1);
    check("term_load_tc", int'(tc), 0);
    check("term_load_out", int'(out), 4);

    // Boundary values: all-ones and 1.
    step(1, MAXV, 0);
    edges_to_tc(MAXV + 5, n);
    check("tc_edges_max", n, MAXV);
    step(1, 1, 0);
    edges_to_tc(5, n);
    check("tc_edges_one", n, 1);

`ifdef DOWN_TIMER_AUTORELOAD_EN
    // Periodic mode: load 3, en held for 12 cycles.
    step(1, 3, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1);
      check("ar_out", int'(out), (3 - ((i + 1) % 4)));
      check("ar_tc",  int'(tc),  int'(((i + 1) % 4) == 3));
      check("ar_busy", int'(busy), 1);
    end
`endif

    // Randomized phase: random loads, load values and enables.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom_range(0, MAXV), $urandom_range(0, 3) != 0);
    end

    // Reset again to finish in a known state.
    do_reset();
    #1;
    check("final_out", int'(out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
